// File: rtl/rom_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ROM.
// Each grant runs IDLE -> READ -> RESP, so one read completes every three cycles.
module rom_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              gnt_s;
  logic              any_req_s;
  logic              gnt_id_r;
  logic              last_gnt_r;
  logic              ack0_r;
  logic              ack1_r;
  logic [DATA_W-1:0] rdata_r;
  logic [ADDR_W-1:0] rom_addr_r;

  // Winner selection and next-state decode
  always_comb begin
    state_s   = state_r;
    gnt_s     = 1'b0;
    any_req_s = req0 | req1;

    // Under contention the requester that did not win last time goes first
    if (req0 && req1) begin
      gnt_s = ~last_gnt_r;
    end else if (req1) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end

    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_s = READ;
        end else begin
          state_s = IDLE;
        end
      end
      READ:    state_s = RESP;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, grant bookkeeping, ROM address, read data and ack registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      gnt_id_r   <= 1'b0;
      last_gnt_r <= 1'b1;
      ack0_r     <= 1'b0;
      ack1_r     <= 1'b0;
      rdata_r    <= '0;
      rom_addr_r <= '0;
    end else begin
      state_r <= state_s;
      ack0_r  <= 1'b0;
      ack1_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            gnt_id_r   <= gnt_s;
            last_gnt_r <= gnt_s;
            rom_addr_r <= gnt_s ? addr1 : addr0;
          end
        end
        READ: begin
          // Ack is raised on entry to RESP so it lines up with the captured data
          rdata_r <= rom_data;
          ack0_r  <= ~gnt_id_r;
          ack1_r  <= gnt_id_r;
        end
        default: begin
        end
      endcase
    end
  end

  assign ack0     = ack0_r;
  assign ack1     = ack1_r;
  assign rdata    = rdata_r;
  assign rom_addr = rom_addr_r;
  assign busy     = (state_r != IDLE);

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed self-checking bench for rom_arbiter with a ROM holding {0,1,2,3,0,1,2,3}.
module tb_rom_arbiter;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 2;

  logic              clk;
  logic              rst;
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              busy;

  logic [DATA_W-1:0] rom_tbl [8];
  int checks;
  int errors;

  rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0),
    .req1(req1), .addr1(addr1),
    .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .rom_addr(rom_addr),
    .rom_data(rom_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb rom_data = rom_tbl[rom_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rom_tbl = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = 3'd0; addr1 = 3'd0;
    step(); step();
    chk("rst_ack0", {31'd0, ack0}, 32'd0);
    chk("rst_ack1", {31'd0, ack1}, 32'd0);
    chk("rst_rdata", {30'd0, rdata}, 32'd0);
    chk("rst_addr", {29'd0, rom_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Single read of address 5: ack two cycles after the IDLE sample
    rst = 1'b0; req0 = 1'b1; addr0 = 3'd5;
    step();
    chk("t1_read_busy", {31'd0, busy}, 32'd1);
    chk("t1_read_addr", {29'd0, rom_addr}, 32'd5);
    chk("t1_read_ack0", {31'd0, ack0}, 32'd0);
    step();
    chk("t1_ack0", {31'd0, ack0}, 32'd1);
    chk("t1_ack1", {31'd0, ack1}, 32'd0);
    chk("t1_rdata", {30'd0, rdata}, 32'd1);
    req0 = 1'b0;
    step();
    chk("t1_idle_ack0", {31'd0, ack0}, 32'd0);
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);

    // Continuous contention from reset: grants alternate 0,1,0,1
    rst = 1'b1; step();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = 3'd2; addr1 = 3'd7;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t2_read_noack", {30'd0, ack0, ack1}, 32'd0);
      step();
      chk("t2_ack0", {31'd0, ack0}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("t2_ack1", {31'd0, ack1}, (k % 2 == 0) ? 32'd0 : 32'd1);
      chk("t2_rdata", {30'd0, rdata}, (k % 2 == 0) ? 32'd2 : 32'd3);
      step();
      chk("t2_idle_noack", {30'd0, ack0, ack1}, 32'd0);
    end

    // Requester 1 alone held 9 cycles: acks at cycles 2,5,8
    req0 = 1'b0; req1 = 1'b0;
    rst = 1'b1; step();
    rst = 1'b0; req1 = 1'b1; addr1 = 3'd3;
    for (int i = 1; i <= 9; i++) begin
      step();
      chk("t3_ack1", {31'd0, ack1}, (i % 3 == 2) ? 32'd1 : 32'd0);
      chk("t3_ack0", {31'd0, ack0}, 32'd0);
      if (i % 3 == 2) chk("t3_rdata", {30'd0, rdata}, 32'd3);
    end
    req1 = 1'b0;

    // Address change after grant must not affect the read
    req0 = 1'b1; addr0 = 3'd4;
    step();
    addr0 = 3'd6;
    chk("t4_read_addr", {29'd0, rom_addr}, 32'd4);
    step();
    chk("t4_ack0", {31'd0, ack0}, 32'd1);
    chk("t4_rdata", {30'd0, rdata}, 32'd0);
    chk("t4_addr_frozen", {29'd0, rom_addr}, 32'd4);
    req0 = 1'b0;
    step();

    // Request withdrawn during READ: ack still pulses once
    req0 = 1'b1; addr0 = 3'd3;
    step();
    req0 = 1'b0;
    step();
    chk("t6_ack0", {31'd0, ack0}, 32'd1);
    chk("t6_rdata", {30'd0, rdata}, 32'd3);
    chk("t6_resp_busy", {31'd0, busy}, 32'd1);
    step();
    chk("t6_idle_busy", {31'd0, busy}, 32'd0);
    chk("t6_idle_ack0", {31'd0, ack0}, 32'd0);
    step();
    chk("t6_no_reack", {30'd0, ack0, ack1}, 32'd0);

    // Reset during READ aborts the transaction and restores priority to requester 0
    req0 = 1'b1; addr0 = 3'd1;
    step();
    chk("t5_read_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_ack", {30'd0, ack0, ack1}, 32'd0);
    chk("t5_rst_rdata", {30'd0, rdata}, 32'd0);
    chk("t5_rst_addr", {29'd0, rom_addr}, 32'd0);
    rst = 1'b0; req1 = 1'b1; addr1 = 3'd6;
    step();
    chk("t5_read_noack", {30'd0, ack0, ack1}, 32'd0);
    step();
    chk("t5_ack0", {31'd0, ack0}, 32'd1);
    chk("t5_ack1", {31'd0, ack1}, 32'd0);
    chk("t5_rdata0", {30'd0, rdata}, 32'd1);
    req0 = 1'b0;
    step();
    step();
    chk("t5_read1_addr", {29'd0, rom_addr}, 32'd6);
    step();
    chk("t5_ack1_second", {31'd0, ack1}, 32'd1);
    chk("t5_rdata1", {30'd0, rdata}, 32'd2);
    req1 = 1'b0;
    step();
    chk("t5_final_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
